rgb_frame_loader: RTL and testbench

//  Byte-stream front end for the RGB memory unit. Parses framed colour-update

---
 rtl/rgb_frame_loader.sv | 205 ++++++++++++++++++++
 tb/tb_rgb_frame_loader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rgb_frame_loader.sv
// Byte-stream front end for the RGB memory unit: parses SYNC/MASK/data frames
// from a valid/ready source and commits staged R/G/B bytes with a one-cycle write pulse.
module rgb_frame_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000,
    parameter int         TO_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] r_data,
    output logic [7:0] g_data,
    output logic [7:0] b_data,
    output logic       we_r,
    output logic       we_g,
    output logic       we_b,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MASK   = 2'd1,
        ST_DATA   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : {TO_W{1'b0}};
    localparam logic TO_EN = (TIMEOUT_CYCLES > 0);

    state_t          state_q, state_d;
    logic [2:0]      mask_q, mask_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [7:0]      r_q, r_d, g_q, g_d, b_q, b_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [2:0]      we_q, we_d;
    logic            accept_s;
    logic            timeout_s;
    logic            mask_bad_s;
    logic [2:0]      first_s;
    logic [2:0]      next_s;

    // Returns {found, index} of the lowest set mask bit at or above 'from'.
    function automatic logic [2:0] next_set(input logic [2:0] m, input logic [1:0] from);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 2; i >= 0; i--) begin
            if (m[i] && (i >= int'(from))) begin
                res = {1'b1, 2'(i)};
            end
        end
        return res;
    endfunction

    assign accept_s   = in_valid & ready_q;
    assign timeout_s  = TO_EN && (to_q == TO_LAST);
    assign mask_bad_s = (in_data[7:3] != 5'd0) || (in_data[2:0] == 3'd0);
    assign first_s    = next_set(in_data[2:0], 2'd0);
    assign next_s     = next_set(mask_q, ptr_q + 2'd1);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; an accept always wins over an expiring timeout.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && (in_data == SYNC_BYTE)) begin
                    state_d = ST_MASK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MASK: begin
                if (accept_s) begin
                    if (mask_bad_s) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_MASK;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    if (next_s[2]) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_COMMIT;
                    end
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and output next values; outputs are decoded from the next state so they register cleanly.
    always_comb begin
        mask_d = mask_q;
        ptr_d  = ptr_q;
        to_d   = {TO_W{1'b0}};
        r_d    = r_q;
        g_d    = g_q;
        b_d    = b_q;
        if ((state_q == ST_MASK) || (state_q == ST_DATA)) begin
            if (accept_s || timeout_s) begin
                to_d = {TO_W{1'b0}};
            end else begin
                to_d = to_q + TO_W'(1);
            end
        end else begin
            to_d = {TO_W{1'b0}};
        end
        if ((state_q == ST_MASK) && accept_s && !mask_bad_s) begin
            mask_d = in_data[2:0];
            ptr_d  = first_s[1:0];
        end else if ((state_q == ST_DATA) && accept_s) begin
            case (ptr_q)
                2'd0:    r_d = in_data;
                2'd1:    g_d = in_data;
                2'd2:    b_d = in_data;
                default: r_d = r_q;
            endcase
            ptr_d = next_s[1:0];
        end else begin
            mask_d = mask_q;
        end
        ready_d = (state_d != ST_COMMIT);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_COMMIT);
        we_d    = (state_d == ST_COMMIT) ? mask_d : 3'b000;
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q  <= 3'b000;
            ptr_q   <= 2'd0;
            to_q    <= {TO_W{1'b0}};
            r_q     <= 8'h00;
            g_q     <= 8'h00;
            b_q     <= 8'h00;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 3'b000;
        end else begin
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
            to_q    <= to_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            we_q    <= we_d;
        end
    end

    assign in_ready   = ready_q;
    assign r_data     = r_q;
    assign g_data     = g_q;
    assign b_data     = b_q;
    assign we_r       = we_q[0];
    assign we_g       = we_q[1];
    assign we_b       = we_q[2];
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_rgb_frame_loader.sv
// Directed, table-driven bench for rgb_frame_loader (timeout shortened to 4 cycles).
module tb_rgb_frame_loader;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] r_data, g_data, b_data;
    logic       we_r, we_g, we_b;
    logic       busy, frame_done, frame_err;

    int n_checks;
    int n_fail;

    typedef struct {
        logic       vld;
        logic [7:0] dat;
        logic       rdy;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [2:0] we;
        logic       bsy;
        logic       done;
        logic       err;
    } vec_t;

    vec_t vq[$];

    rgb_frame_loader #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (4),
        .TO_W           (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .r_data     (r_data),
        .g_data     (g_data),
        .b_data     (b_data),
        .we_r       (we_r),
        .we_g       (we_g),
        .we_b       (we_b),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic vld, input logic [7:0] dat, input logic rdy,
                                input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                input logic [2:0] we, input logic bsy, input logic done,
                                input logic err);
        vec_t v;
        v.vld = vld; v.dat = dat; v.rdy = rdy; v.r = r; v.g = g; v.b = b;
        v.we = we; v.bsy = bsy; v.done = done; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input vec_t e);
        logic [30:0] act, exp;
        act = {in_ready, r_data, g_data, b_data, we_b, we_g, we_r, busy, frame_done, frame_err};
        exp = {e.rdy, e.r, e.g, e.b, e.we, e.bsy, e.done, e.err};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got rdy=%b r=%h g=%h b=%h we(bgr)=%b busy=%b done=%b err=%b ; want rdy=%b r=%h g=%h b=%h we(bgr)=%b busy=%b done=%b err=%b",
                     name, in_ready, r_data, g_data, b_data, {we_b, we_g, we_r}, busy,
                     frame_done, frame_err, e.rdy, e.r, e.g, e.b, e.we, e.bsy, e.done, e.err);
        end
    endtask

    task automatic apply(input string name, input vec_t v);
        in_valid = v.vld;
        in_data  = v.dat;
        @(posedge clk);
        #1;
        check(name, v);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Full RGB frame, then a byte offered during COMMIT that must be ignored.
        vq.push_back(mk(1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 8'hA5, 1'b1, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 8'h07, 1'b1, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 8'h11, 1'b1, 8'h11, 8'h00, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 8'h22, 1'b1, 8'h11, 8'h22, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 8'h33, 1'b0, 8'h11, 8'h22, 8'h33, 3'b111, 1'b1, 1'b1, 1'b0));
        vq.push_back(mk(1'b1, 8'hA5, 1'b1, 8'h11, 8'h22, 8'h33, 3'b000, 1'b0, 1'b0, 1'b0));
        // R+B frame with a one-cycle bubble; green untouched.
        vq.push_back(mk(1'b1, 8'hA5, 1'b1, 8'h11, 8'h22, 8'h33, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 8'h05, 1'b1, 8'h11, 8'h22, 8'h33, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 8'h44, 1'b1, 8'h44, 8'h22, 8'h33, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 8'h00, 1'b1, 8'h44, 8'h22, 8'h33, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 8'h55, 1'b0, 8'h44, 8'h22, 8'h55, 3'b101, 1'b1, 1'b1, 1'b0));
        vq.push_back(mk(1'b0, 8'h00, 1'b1, 8'h44, 8'h22, 8'h55, 3'b000, 1'b0, 1'b0, 1'b0));
        // Bad masks 08, 00, F1.
        vq.push_back(mk(1'b1, 8'hA5, 1'b1, 8'h44, 8'h22, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 8'h08, 1'b1, 8'h44, 8'h22, 8'h55, 3'b000, 1'b0, 1'b0, 1'b1));
        vq.push_back(mk(1'b0, 8'h00, 1'b1, 8'h44, 8'h22, 8'h55, 3'b000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 8'hA5, 1'b1, 8'h44, 8'h22, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 8'h00, 1'b1, 8'h44, 8'h22, 8'h55, 3'b000, 1'b0, 1'b0, 1'b1));
        vq.push_back(mk(1'b1, 8'hA5, 1'b1, 8'h44, 8'h22, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 8'hF1, 1'b1, 8'h44, 8'h22, 8'h55, 3'b000, 1'b0, 1'b0, 1'b1));
        // Junk discarded, then green frame carrying payload A5.
        vq.push_back(mk(1'b1, 8'h00, 1'b1, 8'h44, 8'h22, 8'h55, 3'b000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 8'hFF, 1'b1, 8'h44, 8'h22, 8'h55, 3'b000, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 8'hA5, 1'b1, 8'h44, 8'h22, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 8'h02, 1'b1, 8'h44, 8'h22, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 8'hA5, 1'b0, 8'h44, 8'hA5, 8'h55, 3'b010, 1'b1, 1'b1, 1'b0));
        vq.push_back(mk(1'b0, 8'h00, 1'b1, 8'h44, 8'hA5, 8'h55, 3'b000, 1'b0, 1'b0, 1'b0));
        // Timeout in DATA after A5,01: error on the 4th idle cycle.
        vq.push_back(mk(1'b1, 8'hA5, 1'b1, 8'h44, 8'hA5, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 8'h01, 1'b1, 8'h44, 8'hA5, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(1'b0, 8'h00, 1'b1, 8'h44, 8'hA5, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 8'h00, 1'b1, 8'h44, 8'hA5, 8'h55, 3'b000, 1'b0, 1'b0, 1'b1));
        vq.push_back(mk(1'b0, 8'h00, 1'b1, 8'h44, 8'hA5, 8'h55, 3'b000, 1'b0, 1'b0, 1'b0));
        // Partial R+G frame times out; red keeps 77, green keeps A5.
        vq.push_back(mk(1'b1, 8'hA5, 1'b1, 8'h44, 8'hA5, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 8'h03, 1'b1, 8'h44, 8'hA5, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 8'h77, 1'b1, 8'h77, 8'hA5, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(1'b0, 8'h00, 1'b1, 8'h77, 8'hA5, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 8'h00, 1'b1, 8'h77, 8'hA5, 8'h55, 3'b000, 1'b0, 1'b0, 1'b1));
        // Timeout while waiting for the mask byte.
        vq.push_back(mk(1'b1, 8'hA5, 1'b1, 8'h77, 8'hA5, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(1'b0, 8'h00, 1'b1, 8'h77, 8'hA5, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 8'h00, 1'b1, 8'h77, 8'hA5, 8'h55, 3'b000, 1'b0, 1'b0, 1'b1));
        // Stall of 3 cycles, then the data byte still commits.
        vq.push_back(mk(1'b1, 8'hA5, 1'b1, 8'h77, 8'hA5, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 8'h01, 1'b1, 8'h77, 8'hA5, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(1'b0, 8'h00, 1'b1, 8'h77, 8'hA5, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 8'h66, 1'b0, 8'h66, 8'hA5, 8'h55, 3'b001, 1'b1, 1'b1, 1'b0));
        vq.push_back(mk(1'b0, 8'h00, 1'b1, 8'h66, 8'hA5, 8'h55, 3'b000, 1'b0, 1'b0, 1'b0));

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", mk(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0));
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            apply($sformatf("vec%0d", i), vq[i]);
        end

        // Asynchronous reset in the middle of a frame.
        apply("rst_pre0", mk(1'b1, 8'hA5, 1'b1, 8'h66, 8'hA5, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0));
        apply("rst_pre1", mk(1'b1, 8'h07, 1'b1, 8'h66, 8'hA5, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0));
        apply("rst_pre2", mk(1'b1, 8'h11, 1'b1, 8'h11, 8'hA5, 8'h55, 3'b000, 1'b1, 1'b0, 1'b0));
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", mk(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        check("rst_held", mk(1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0));
        rst = 1'b0;
        apply("post0", mk(1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0));
        apply("post1", mk(1'b1, 8'hA5, 1'b1, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0));
        apply("post2", mk(1'b1, 8'h07, 1'b1, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0));
        apply("post3", mk(1'b1, 8'h01, 1'b1, 8'h01, 8'h00, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0));
        apply("post4", mk(1'b1, 8'h02, 1'b1, 8'h01, 8'h02, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0));
        apply("post5", mk(1'b1, 8'h03, 1'b0, 8'h01, 8'h02, 8'h03, 3'b111, 1'b1, 1'b1, 1'b0));
        apply("post6", mk(1'b0, 8'h00, 1'b1, 8'h01, 8'h02, 8'h03, 3'b000, 1'b0, 1'b0, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
